// File: rtl/memory_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_ctrl_if : MEM-stage, fetch and UART/7-seg signal bundle for memory_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
interface memory_ctrl_if #(
  parameter int SEG_W = 16
);
  logic [2:0]       funct3;
  logic [31:0]      addr_inst;
  logic [31:0]      readdata_inst;
  logic [31:0]      addr;
  logic [31:0]      writedata;
  logic             writectrl;
  logic             readctrl;
  logic [31:0]      readdata;
  logic             empty;
  logic [7:0]       uart_in;
  logic             rdreq;
  logic             txfull;
  logic [7:0]       uart_out;
  logic             wrreq;
  logic [SEG_W-1:0] seg_io;
  logic             clken;
  logic             misalign;

  modport slave (
    input  funct3, addr_inst, addr, writedata, writectrl, readctrl, empty, uart_in, txfull,
    output readdata_inst, readdata, rdreq, uart_out, wrreq, seg_io, clken, misalign
  );

  modport master (
    output funct3, addr_inst, addr, writedata, writectrl, readctrl, empty, uart_in, txfull,
    input  readdata_inst, readdata, rdreq, uart_out, wrreq, seg_io, clken, misalign
  );
endinterface
`default_nettype wire

// File: rtl/memory_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memory_ctrl : dual-port RAM with RV32 lane handling, 7-seg/UART MMIO, FIFO stalls
// Revision: 1.0
// ---------------------------------------------------------------------------
module memory_ctrl #(
  parameter int          ADDR_W         = 15,
  parameter int          SEG_W          = 16,
  parameter logic [31:0] SEG_ADDR       = 32'h0,
  parameter logic [31:0] UART_DATA_ADDR = 32'h4,
  parameter logic [31:0] UART_STAT_ADDR = 32'h8
) (
  input  logic         clk,
  input  logic         rst_n,
  memory_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, RX_WAIT = 2'd1, TX_WAIT = 2'd2} state_t;
  state_t r_state, w_next;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_rd_word, r_inst_word;
  logic              r_inst_vld;
  logic [SEG_W-1:0]  r_seg;
  logic [7:0]        r_tx_byte;
  logic              r_ld_vld, r_ld_ram;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_off;
  logic [31:0]       r_ld_word;

  logic [ADDR_W-1:0] w_idx, w_iidx;
  logic              w_is_seg, w_is_uart, w_is_stat, w_sz_b, w_sz_h, w_mis, w_run, w_st, w_ld;
  logic              w_rdreq, w_wrreq, w_ram_we, w_seg_we, w_tx_latch, w_ld_fire, w_ld_ram;
  logic [7:0]        w_uart_out, w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld_word, w_wdata, w_src, w_ext;
  logic [3:0]        w_be;
  logic              w_unused_inst;

  assign w_idx     = bus.addr[ADDR_W+1:2];
  assign w_iidx    = bus.addr_inst[ADDR_W+1:2];
  assign w_unused_inst = ^{bus.addr_inst[31:ADDR_W+2], bus.addr_inst[1:0]};
  assign w_is_seg  = (bus.addr == SEG_ADDR);
  assign w_is_uart = (bus.addr == UART_DATA_ADDR);
  assign w_is_stat = (bus.addr == UART_STAT_ADDR);
  assign w_sz_b    = (bus.funct3[1:0] == 2'b00);
  assign w_sz_h    = (bus.funct3[1:0] == 2'b01);
  // Any width code other than byte/half (incl. 011/110/111) behaves as a word.
  assign w_mis     = (w_sz_h & bus.addr[0]) | (~w_sz_b & ~w_sz_h & (|bus.addr[1:0]));
  assign w_run     = (r_state == RUN);
  assign w_st      = w_run & bus.writectrl & ~w_mis;
  assign w_ld      = w_run & bus.readctrl & ~bus.writectrl & ~w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_rdreq    = 1'b0;
    w_wrreq    = 1'b0;
    w_uart_out = bus.writedata[7:0];
    w_ram_we   = 1'b0;
    w_seg_we   = 1'b0;
    w_tx_latch = 1'b0;
    w_ld_fire  = 1'b0;
    w_ld_ram   = 1'b0;
    w_ld_word  = '0;
    case (r_state)
      RUN: begin
        if (w_st) begin
          if (w_is_seg) w_seg_we = 1'b1;
          else if (w_is_uart) begin
            if (bus.txfull) begin
              w_tx_latch = 1'b1;
              w_next     = TX_WAIT;
            end else w_wrreq = 1'b1;
          end else if (!w_is_stat) w_ram_we = 1'b1;
        end else if (w_ld) begin
          if (w_is_uart) begin
            if (bus.empty) w_next = RX_WAIT;
            else begin
              w_rdreq   = 1'b1;
              w_ld_fire = 1'b1;
              w_ld_word = {24'b0, bus.uart_in};
            end
          end else begin
            w_ld_fire = 1'b1;
            if (w_is_stat)     w_ld_word = {30'b0, bus.txfull, ~bus.empty};
            else if (!w_is_seg) w_ld_ram = 1'b1;
          end
        end
      end
      RX_WAIT: begin
        if (!bus.empty) begin
          w_rdreq   = 1'b1;
          w_ld_fire = 1'b1;
          w_ld_word = {24'b0, bus.uart_in};
          w_next    = RUN;
        end
      end
      TX_WAIT: begin
        w_uart_out = r_tx_byte;
        if (!bus.txfull) begin
          w_wrreq = 1'b1;
          w_next  = RUN;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.writedata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.writedata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.writedata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
    r_rd_word   <= r_mem[w_idx];
    r_inst_word <= r_mem[w_iidx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_vld <= 1'b0;
      r_seg      <= '0;
      r_tx_byte  <= '0;
      r_ld_vld   <= 1'b0;
      r_ld_ram   <= 1'b0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
      r_ld_word  <= '0;
    end else begin
      r_inst_vld <= 1'b1;
      if (w_seg_we)   r_seg     <= bus.writedata[SEG_W-1:0];
      if (w_tx_latch) r_tx_byte <= bus.writedata[7:0];
      r_ld_vld <= w_ld_fire;
      if (w_ld_fire) begin
        r_ld_f3   <= bus.funct3;
        r_ld_off  <= bus.addr[1:0];
        r_ld_ram  <= w_ld_ram;
        r_ld_word <= w_ld_word;
      end
    end
  end

  assign w_src  = r_ld_ram ? r_rd_word : r_ld_word;
  assign w_byte = w_src[8*r_ld_off +: 8];
  assign w_half = r_ld_off[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    case (r_ld_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'b0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'b0, w_half};
      default: w_ext = w_src;
    endcase
  end

  assign bus.readdata      = r_ld_vld ? w_ext : 32'h0;
  assign bus.readdata_inst = r_inst_vld ? r_inst_word : 32'h0;
  assign bus.seg_io        = r_seg;
  assign bus.uart_out      = w_uart_out;
  // Strobes are combinational, so hold them off while reset is asserted.
  assign bus.rdreq         = w_rdreq & rst_n;
  assign bus.wrreq         = w_wrreq & rst_n;
  assign bus.misalign      = w_run & (bus.readctrl | bus.writectrl) & w_mis & rst_n;
  assign bus.clken         = w_run;

endmodule
`default_nettype wire

// File: tb/tb_memory_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_memory_ctrl : vector table + scoreboard bench for memory_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_memory_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_ctrl_if #(.SEG_W(16)) bus ();

  memory_ctrl #(
    .ADDR_W(15), .SEG_W(16),
    .SEG_ADDR(32'h0), .UART_DATA_ADDR(32'h4), .UART_STAT_ADDR(32'h8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 25;
  vec_t        vecs [NV];
  logic [31:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stalls, strobes;
  logic        released;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.writectrl = 1'b0;
    bus.readctrl  = 1'b0;
    bus.funct3    = 3'b010;
    bus.addr      = 32'h0;
    bus.writedata = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    bus.writectrl = v.wr;
    bus.readctrl  = v.rd;
    bus.funct3    = v.f3;
    bus.addr      = v.a;
    bus.writedata = v.wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100,   32'h11223344, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h101,   32'h000000AA, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'h102,   32'h0000BEEF, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h100,   32'h0,        32'hBEEFAA44, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h101,   32'h0,        32'hFFFFFFAA, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'b100, 32'h101,   32'h0,        32'h000000AA, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h102,   32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b101, 32'h102,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h102,   32'hDEAD0000, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h100,   32'h0,        32'hBEEFAA44, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h101,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 1'b1, 3'b000, 32'h102,   32'h0,        32'hFFFFFFEF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h20100, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b011, 32'h100,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h103,   32'h00000080, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'b000, 32'h103,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'b101, 32'h102,   32'h0,        32'h000080FE, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'b110, 32'h100,   32'h0,        32'h80FEF00D, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 3'b010, 32'h200,   32'h00000055, 32'h0,        1'b0};
    vecs[19] = '{1'b0, 1'b1, 3'b010, 32'h200,   32'h0,        32'h00000055, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 3'b010, 32'h0,     32'h00001234, 32'h0,        1'b0};
    vecs[21] = '{1'b0, 1'b1, 3'b010, 32'h0,     32'h0,        32'h0,        1'b0};
    vecs[22] = '{1'b0, 1'b1, 3'b010, 32'h8,     32'h0,        32'h00000002, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 3'b011, 32'h103,   32'h0,        32'h0,        1'b1};
    vecs[24] = '{1'b1, 1'b0, 3'b001, 32'h103,   32'h0000FFFF, 32'h0,        1'b1};

    idle();
    bus.addr_inst = 32'h100;
    bus.empty     = 1'b1;
    bus.uart_in   = 8'h0;
    bus.txfull    = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_clken", {31'b0, bus.clken}, 32'h1);
    check("rst_seg", {16'b0, bus.seg_io}, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_readdata_inst", bus.readdata_inst, 32'h0);
    check("rst_strobes", {29'b0, bus.rdreq, bus.wrreq, bus.misalign}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k]);
      @(negedge clk);
      check($sformatf("misalign[%0d]", k), {31'b0, bus.misalign}, {31'b0, vecs[k].exp_mis});
      if (sb_q.size() > 0) check($sformatf("readdata[%0d]", k - 1), bus.readdata, sb_q.pop_front());
      sb_q.push_back(vecs[k].exp_rd);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check($sformatf("readdata[%0d]", NV - 1), bus.readdata, sb_q.pop_front());
    check("seg_io", {16'b0, bus.seg_io}, 32'h00001234);
    check("fetch_0x100", bus.readdata_inst, 32'h80FEF00D);

    // Blocking RX: FIFO empty for 5 cycles, then 0x5A arrives.
    @(posedge clk); #1;
    bus.readctrl = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h4; bus.empty = 1'b1;
    @(negedge clk);
    check("rx_req_clken", {31'b0, bus.clken}, 32'h1);
    stalls = 0; strobes = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin bus.empty = 1'b0; bus.uart_in = 8'h5A; end
      @(negedge clk);
      if (!bus.clken) stalls++;
      if (bus.rdreq) strobes++;
    end
    sb_q.push_back(32'h0000005A);
    @(posedge clk); #1;
    idle(); bus.empty = 1'b1; bus.uart_in = 8'h0;
    @(negedge clk);
    check("rx_readdata", bus.readdata, sb_q.pop_front());
    check("rx_clken_back", {31'b0, bus.clken}, 32'h1);
    check("rx_stall_cycles", stalls, 32'd5);
    check("rx_rdreq_pulses", strobes, 32'd1);

    // TX back-pressure: txfull high for 3 cycles including the request cycle.
    @(posedge clk); #1;
    bus.writectrl = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h4; bus.writedata = 32'h41; bus.txfull = 1'b1;
    @(negedge clk);
    check("tx_req_wrreq", {31'b0, bus.wrreq}, 32'h0);
    stalls = 0; strobes = 0; released = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c >= 3) bus.txfull = 1'b0;
      if (released) idle();
      @(negedge clk);
      if (!bus.clken) stalls++;
      if (bus.wrreq) begin
        strobes++;
        check("tx_uart_out", {24'b0, bus.uart_out}, 32'h41);
        released = 1'b1;
      end
    end
    check("tx_stall_cycles", stalls, 32'd3);
    check("tx_wrreq_pulses", strobes, 32'd1);

    // Status word sampled in the request cycle.
    @(posedge clk); #1;
    bus.readctrl = 1'b1; bus.addr = 32'h8; bus.empty = 1'b0; bus.txfull = 1'b0;
    sb_q.push_back(32'h1);
    @(negedge clk);
    @(posedge clk); #1;
    bus.empty = 1'b1; bus.txfull = 1'b1;
    @(negedge clk);
    check("stat_a", bus.readdata, sb_q.pop_front());
    sb_q.push_back(32'h2);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("stat_b", bus.readdata, sb_q.pop_front());
    check("stat_no_pop", {31'b0, bus.rdreq}, 32'h0);

    // Reset while parked in RX_WAIT.
    @(posedge clk); #1;
    bus.readctrl = 1'b1; bus.addr = 32'h4; bus.empty = 1'b1;
    repeat (3) @(negedge clk);
    check("rxw_stalled", {31'b0, bus.clken}, 32'h0);
    rst_n = 1'b0;
    bus.empty = 1'b0; bus.uart_in = 8'h77;
    #1;
    check("rxw_rst_clken", {31'b0, bus.clken}, 32'h1);
    check("rxw_rst_seg", {16'b0, bus.seg_io}, 32'h0);
    check("rxw_rst_rdreq", {31'b0, bus.rdreq}, 32'h0);
    @(posedge clk); #1;
    check("rxw_rst_rdreq_edge", {31'b0, bus.rdreq}, 32'h0);
    check("rxw_rst_readdata", bus.readdata, 32'h0);
    idle(); bus.empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rdreq) strobes++;
    end
    check("rxw_post_rdreq", strobes, 32'd0);
    check("rxw_post_clken", {31'b0, bus.clken}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/memory_ctrl.md
# memory_ctrl

Parametrised successor of the core's data-memory unit: a dual-port inferred RAM (instruction fetch port plus data load/store port) with RV32 byte/halfword/word lane handling and a small MMIO window (7-segment register, UART RX data, UART TX data, UART status). A three-state controller blocks the pipeline through `clken` while it waits on an empty RX FIFO or a full TX FIFO. It sits between the core's MEM stage and the board I/O, and adds correct sub-word stores and TX back-pressure.

## Interface
- `ADDR_W`, 15: word-address bits; RAM depth is 2^ADDR_W words; RAM is indexed by `addr[ADDR_W+1:2]`.
- `SEG_W`, 16: width of `seg_io`.
- `SEG_ADDR`, 32'h0: 7-segment register; write-only.
- `UART_DATA_ADDR`, 32'h4: RX pop on load, TX push on store.
- `UART_STAT_ADDR`, 32'h8: read-only status word.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `funct3` in 3: RV32 load/store width code.
- `addr_inst` in 32: fetch byte address.
- `readdata_inst` out 32: fetched word.
- `addr` in 32: data byte address.
- `writedata` in 32: store data.
- `writectrl` in 1: store request.
- `readctrl` in 1: load request.
- `readdata` out 32: load result.
- `empty` in 1: RX FIFO empty. The FIFO is show-ahead: `uart_in` is valid whenever `empty`=0.
- `uart_in` in 8: RX head byte.
- `rdreq` out 1: RX pop.
- `txfull` in 1: TX FIFO full.
- `uart_out` out 8: TX byte.
- `wrreq` out 1: TX push.
- `seg_io` out SEG_W: 7-segment register.
- `clken` out 1: pipeline enable; 0 = stall.
- `misalign` out 1: one-cycle pulse flagging a misaligned access.

## Operation
- **States:** RUN, RX_WAIT, TX_WAIT. The MEM-stage inputs are frozen by the core while `clken`=0.
- `clken` is 1 only in RUN.
- **RAM writes:** requires `writectrl` in RUN, an address outside the MMIO window, and an aligned access.
  - sb: data replicated to all lanes, byteena = 1<<addr[1:0].
  - sh: byteena = 0011 or 1100 by addr[1].
  - sw: byteena = 1111.
- **Misaligned accesses:** sh/lh/lhu with addr[0]=1, or sw/lw with addr[1:0]!=0.
  - The write is suppressed and the load returns 0.
  - `misalign`=1 in the request cycle.
- **Loads:** `funct3`, addr[1:0], the source select and a valid flag are registered in the request cycle.
  - The result is selected combinationally the next cycle: b/h sign-extended, bu/hu zero-extended, w passthrough.
  - funct3 011/110/111 is treated as lw.
- **Load sources:**
  - UART_STAT load returns {30'b0, txfull, ~empty}, sampled in the request cycle.
  - SEG_ADDR load returns 0.
- **UART load in RUN:**
  - With `empty`=0: `rdreq`=1 the same cycle and `uart_in` is captured.
  - With `empty`=1: go to RX_WAIT.
- **RX_WAIT:** `rdreq`=~empty. On the cycle `empty`=0, capture `uart_in` and go to RUN.
- **UART store in RUN:**
  - With `txfull`=0: `wrreq`=1 with `uart_out`=writedata[7:0].
  - With `txfull`=1: latch writedata[7:0] and go to TX_WAIT.
- **TX_WAIT:** `wrreq`=~txfull with `uart_out` driven from the latch. On the push, go to RUN.
- **SEG store:** in RUN, `seg_io` <= writedata[SEG_W-1:0] on the next edge.
- **Simultaneous `readctrl` and `writectrl`:** the store wins and the load result is 0.

## Timing
- **Reset values:** state=RUN, `seg_io`=0, valid flag=0, `readdata`=0, `readdata_inst`=0 (gated until the first post-reset edge), `rdreq`=`wrreq`=`misalign`=0, `clken`=1.
- **Reset mid-wait:** return to RUN with no pop or push issued.
- **Fetch:** `readdata_inst` is valid 1 cycle after `addr_inst`. The fetch port is unaffected by stalls.
- **Load latency:** request at cycle N, `readdata` valid at N+1. `readdata` is 0 at N+1 if no load was issued at N.
- **Blocking RX:** request at N, FIFO empty until M. State is RX_WAIT over N+1..M, `rdreq`=1 at M, and RUN plus the byte on `readdata` at M+1.
- **TX stall:** `clken`=0 for exactly the cycles `txfull` stays 1 after entry.
- **Pointer wrap:** RAM addresses wrap modulo 2^ADDR_W words.

## Test plan
- **Byte-lane stores:** sw 0x11223344 @0x100; sb 0xAA @0x101; sh 0xBEEF @0x102; then lw @0x100 -> 0xBEEFAA44.
- **Load extension:** lb @0x101 -> 0xFFFFFFAA; lbu -> 0x000000AA; lh @0x102 -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
- **Misaligned:** sw @0x102 -> `misalign` pulse, RAM unchanged; lh @0x101 -> `readdata`=0.
- **Blocking RX:** lw @0x4 with `empty`=1 for 5 cycles, then `uart_in`=0x5A -> `clken`=0 for 5 cycles, one `rdreq` pulse, `readdata`=0x0000005A.
- **TX back-pressure:** sw 0x41 @0x4 with `txfull`=1 for 3 cycles -> `clken` low 3 cycles, single `wrreq` with `uart_out`=0x41; status read afterward -> {30'b0, 0, ~empty}.
- **Reset mid-wait:** assert `rst_n`=0 during RX_WAIT -> state RUN, `seg_io`=0, no `rdreq` issued.
